exec_datapath: RTL and testbench

//  Execute stage of the 8-bit multi-cycle CPU: instruction decode, ALU and data memory in one block.

---
 rtl/exec_pkg.sv | 98 +++++++++
 rtl/exec_alu.sv | 67 ++++++
 rtl/exec_datapath.sv | 156 +++++++++++++++
 tb/tb_exec_datapath.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// exec_pkg: shared types and constants for the 8-bit execute stage.
//  - DATA_W / field widths, opcode encodings, link register index
//  - ctrl_t decode bundle {reg_w_en, mem_w_en, mem_r_en, wb_sel, br_type}
//  - decode(): opcode -> ctrl_t
// Build option: ALU_SHIFT_EN (defined: SLL/SRL write back; undefined: they are NOPs).
package exec_pkg;

   localparam int unsigned DATA_W  = 8;
   localparam int unsigned INSTR_W = 8;
   localparam int unsigned OP_W    = 4;
   localparam int unsigned RADDR_W = 2;

   localparam logic [RADDR_W-1:0] LINK_REG = RADDR_W'(3);

   localparam logic [OP_W-1:0] OP_ADD  = 4'h0;
   localparam logic [OP_W-1:0] OP_SUB  = 4'h1;
   localparam logic [OP_W-1:0] OP_AND  = 4'h2;
   localparam logic [OP_W-1:0] OP_OR   = 4'h3;
   localparam logic [OP_W-1:0] OP_XOR  = 4'h4;
   localparam logic [OP_W-1:0] OP_NOT  = 4'h5;
   localparam logic [OP_W-1:0] OP_SLL  = 4'h6;
   localparam logic [OP_W-1:0] OP_SRL  = 4'h7;
   localparam logic [OP_W-1:0] OP_SLT  = 4'h8;
   localparam logic [OP_W-1:0] OP_LW   = 4'h9;
   localparam logic [OP_W-1:0] OP_SW   = 4'hA;
   localparam logic [OP_W-1:0] OP_ADDI = 4'hB;
   localparam logic [OP_W-1:0] OP_BEQ  = 4'hC;
   localparam logic [OP_W-1:0] OP_BNE  = 4'hD;
   localparam logic [OP_W-1:0] OP_J    = 4'hE;
   localparam logic [OP_W-1:0] OP_JAL  = 4'hF;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_MEM = 2'd1,
      WB_PC1 = 2'd2
   } wb_sel_e;

   typedef enum logic [1:0] {
      BR_NONE = 2'd0,
      BR_EQ   = 2'd1,
      BR_NE   = 2'd2,
      BR_JMP  = 2'd3
   } br_type_e;

   typedef struct packed {
      logic     reg_w_en;
      logic     mem_w_en;
      logic     mem_r_en;
      wb_sel_e  wb_sel;
      br_type_e br_type;
   } ctrl_t;

   // Opcode -> control bundle; default is an ALU op that writes ra.
   function automatic ctrl_t decode(input logic [OP_W-1:0] op);
      ctrl_t c;
      c.reg_w_en = 1'b1;
      c.mem_w_en = 1'b0;
      c.mem_r_en = 1'b0;
      c.wb_sel   = WB_ALU;
      c.br_type  = BR_NONE;
      case (op)
         OP_SLL, OP_SRL: begin
`ifdef ALU_SHIFT_EN
            c.reg_w_en = 1'b1;
`else
            c.reg_w_en = 1'b0;
`endif
         end
         OP_LW: begin
            c.mem_r_en = 1'b1;
            c.wb_sel   = WB_MEM;
         end
         OP_SW: begin
            c.reg_w_en = 1'b0;
            c.mem_w_en = 1'b1;
         end
         OP_BEQ: begin
            c.reg_w_en = 1'b0;
            c.br_type  = BR_EQ;
         end
         OP_BNE: begin
            c.reg_w_en = 1'b0;
            c.br_type  = BR_NE;
         end
         OP_J: begin
            c.reg_w_en = 1'b0;
            c.br_type  = BR_JMP;
         end
         OP_JAL: begin
            c.br_type  = BR_JMP;
            c.wb_sel   = WB_PC1;
         end
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/exec_alu.sv
// exec_alu: combinational ALU for the execute stage.
//  op         in  opcode
//  a, b       in  operands (R[ra], R[rb])
//  imm        in  ADDI immediate (instr[1:0], zero-extended)
//  result_c   out ALU result, 0 for opcodes the ALU does not produce
//  overflow_c out signed overflow for ADD/SUB/ADDI, 0 otherwise
// Build option: ALU_SHIFT_EN enables the SLL/SRL shifters.
module exec_alu
   import exec_pkg::*;
(
   input  logic [OP_W-1:0]    op,
   input  logic [DATA_W-1:0]  a,
   input  logic [DATA_W-1:0]  b,
   input  logic [RADDR_W-1:0] imm,
   output logic [DATA_W-1:0]  result_c,
   output logic               overflow_c
);

   localparam int unsigned MSB = DATA_W - 1;

   logic [DATA_W-1:0] sum;
   logic [DATA_W-1:0] diff;
   logic [DATA_W-1:0] addi_sum;

`ifdef ALU_SHIFT_EN
   localparam int unsigned SH_W = $clog2(DATA_W);
   logic [SH_W-1:0] shamt;
   assign shamt = b[SH_W-1:0];
`endif

   // Shared adders; overflow is judged from operand and result sign bits.
   always_comb begin
      sum        = a + b;
      diff       = a - b;
      addi_sum   = a + DATA_W'(imm);
      result_c   = '0;
      overflow_c = 1'b0;
      case (op)
         OP_ADD: begin
            result_c   = sum;
            overflow_c = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
         end
         OP_SUB: begin
            result_c   = diff;
            overflow_c = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
         end
         OP_AND: result_c = a & b;
         OP_OR:  result_c = a | b;
         OP_XOR: result_c = a ^ b;
         OP_NOT: result_c = ~b;
`ifdef ALU_SHIFT_EN
         OP_SLL: result_c = a << shamt;
         OP_SRL: result_c = a >> shamt;
`else
         OP_SLL, OP_SRL: result_c = '0;
`endif
         OP_SLT: result_c = DATA_W'($signed(a) < $signed(b));
         OP_ADDI: begin
            // Immediate is non-negative, so only a positive wrap can overflow.
            result_c   = addi_sum;
            overflow_c = !a[MSB] && addi_sum[MSB];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/exec_datapath.sv
// exec_datapath: execute stage of the 8-bit multi-cycle CPU (decode, ALU, data memory).
//  clk, rst_n                 clock, synchronous active-low reset
//  instr, instr_valid         instruction {op[7:4], ra[3:2], rb[1:0]} and execute strobe
//  pc, in0, in1, jump_offset  PC of instr, R[ra], R[rb], R0 (signed branch offset)
//  reg_addr_0/1               combinational register read addresses (ra, rb)
//  reg_addr_w, reg_w_en       registered writeback destination / enable
//  wb_data, overflow          registered writeback value / signed overflow
//  branch_taken, pc_next      registered branch outcome / next PC
//  out_valid                  one-cycle pulse after each executed instruction
// Build option: ALU_SHIFT_EN (defined: SLL/SRL active; undefined: SLL/SRL are NOPs).
module exec_datapath
   import exec_pkg::*;
#(
   parameter int unsigned DMEM_DEPTH = 256
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [INSTR_W-1:0]  instr,
   input  logic                instr_valid,
   input  logic [DATA_W-1:0]   pc,
   input  logic [DATA_W-1:0]   in0,
   input  logic [DATA_W-1:0]   in1,
   input  logic [DATA_W-1:0]   jump_offset,
   output logic [RADDR_W-1:0]  reg_addr_0,
   output logic [RADDR_W-1:0]  reg_addr_1,
   output logic [RADDR_W-1:0]  reg_addr_w,
   output logic                reg_w_en,
   output logic [DATA_W-1:0]   wb_data,
   output logic                overflow,
   output logic                branch_taken,
   output logic [DATA_W-1:0]   pc_next,
   output logic                out_valid
);

   localparam int unsigned MEM_AW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

   logic [OP_W-1:0]    opcode;
   logic [RADDR_W-1:0] ra;
   logic [RADDR_W-1:0] rb;
   ctrl_t              ctrl;

   logic [DATA_W-1:0]  alu_result;
   logic               alu_ovf;
   logic [MEM_AW-1:0]  mem_addr;
   logic [DATA_W-1:0]  mem_rdata;
   logic [DATA_W-1:0]  pc_inc;
   logic [DATA_W-1:0]  br_target;
   logic               taken;

   logic [DATA_W-1:0]  dmem_q [DMEM_DEPTH];

   logic [RADDR_W-1:0] reg_addr_w_q, reg_addr_w_d;
   logic               reg_w_en_q,   reg_w_en_d;
   logic [DATA_W-1:0]  wb_data_q,    wb_data_d;
   logic               overflow_q,   overflow_d;
   logic               br_taken_q,   br_taken_d;
   logic [DATA_W-1:0]  pc_next_q,    pc_next_d;
   logic               out_valid_q,  out_valid_d;

   assign opcode     = instr[7:4];
   assign ra         = instr[3:2];
   assign rb         = instr[1:0];
   assign reg_addr_0 = ra;
   assign reg_addr_1 = rb;

   assign ctrl = decode(opcode);

   exec_alu u_alu (
      .op         (opcode),
      .a          (in0),
      .b          (in1),
      .imm        (rb),
      .result_c   (alu_result),
      .overflow_c (alu_ovf)
   );

   // Address, memory read and branch arithmetic, all mod 2^DATA_W.
   always_comb begin
      mem_addr  = MEM_AW'(32'(in1) % DMEM_DEPTH);
      mem_rdata = ctrl.mem_r_en ? dmem_q[mem_addr] : '0;
      pc_inc    = pc + DATA_W'(1);
      br_target = pc_inc + jump_offset;
      case (ctrl.br_type)
         BR_EQ:   taken = (in0 == in1);
         BR_NE:   taken = (in0 != in1);
         BR_JMP:  taken = 1'b1;
         default: taken = 1'b0;
      endcase
   end

   // Data memory: not reset; a store coinciding with reset is dropped.
   always_ff @(posedge clk) begin
      if (rst_n && instr_valid && ctrl.mem_w_en) begin
         dmem_q[mem_addr] <= in0;
      end
   end

   // Next-state for the result registers; they hold when no instruction executes.
   always_comb begin
      reg_addr_w_d = reg_addr_w_q;
      reg_w_en_d   = reg_w_en_q;
      wb_data_d    = wb_data_q;
      overflow_d   = overflow_q;
      br_taken_d   = br_taken_q;
      pc_next_d    = pc_next_q;
      out_valid_d  = 1'b0;
      if (instr_valid) begin
         out_valid_d  = 1'b1;
         reg_addr_w_d = (opcode == OP_JAL) ? LINK_REG : ra;
         reg_w_en_d   = ctrl.reg_w_en;
         case (ctrl.wb_sel)
            WB_MEM:  wb_data_d = mem_rdata;
            WB_PC1:  wb_data_d = pc_inc;
            default: wb_data_d = alu_result;
         endcase
         overflow_d = alu_ovf;
         br_taken_d = taken;
         if (!taken) begin
            pc_next_d = pc_inc;
         end else if (ctrl.br_type == BR_JMP) begin
            pc_next_d = in1;
         end else begin
            pc_next_d = br_target;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         reg_addr_w_q <= '0;
         reg_w_en_q   <= 1'b0;
         wb_data_q    <= '0;
         overflow_q   <= 1'b0;
         br_taken_q   <= 1'b0;
         pc_next_q    <= '0;
         out_valid_q  <= 1'b0;
      end else begin
         reg_addr_w_q <= reg_addr_w_d;
         reg_w_en_q   <= reg_w_en_d;
         wb_data_q    <= wb_data_d;
         overflow_q   <= overflow_d;
         br_taken_q   <= br_taken_d;
         pc_next_q    <= pc_next_d;
         out_valid_q  <= out_valid_d;
      end
   end

   assign reg_addr_w   = reg_addr_w_q;
   assign reg_w_en     = reg_w_en_q;
   assign wb_data      = wb_data_q;
   assign overflow     = overflow_q;
   assign branch_taken = br_taken_q;
   assign pc_next      = pc_next_q;
   assign out_valid    = out_valid_q;

endmodule

// File: tb/tb_exec_datapath.sv
// tb_exec_datapath: randomized + directed bench for exec_datapath with an
// arithmetic reference model of the execute stage and its data memory.
// Honours ALU_SHIFT_EN the same way the design does.
module tb_exec_datapath;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] instr;
   logic       instr_valid;
   logic [7:0] pc;
   logic [7:0] in0;
   logic [7:0] in1;
   logic [7:0] jump_offset;
   logic [1:0] reg_addr_0;
   logic [1:0] reg_addr_1;
   logic [1:0] reg_addr_w;
   logic       reg_w_en;
   logic [7:0] wb_data;
   logic       overflow;
   logic       branch_taken;
   logic [7:0] pc_next;
   logic       out_valid;

   exec_datapath dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .instr        (instr),
      .instr_valid  (instr_valid),
      .pc           (pc),
      .in0          (in0),
      .in1          (in1),
      .jump_offset  (jump_offset),
      .reg_addr_0   (reg_addr_0),
      .reg_addr_1   (reg_addr_1),
      .reg_addr_w   (reg_addr_w),
      .reg_w_en     (reg_w_en),
      .wb_data      (wb_data),
      .overflow     (overflow),
      .branch_taken (branch_taken),
      .pc_next      (pc_next),
      .out_valid    (out_valid)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int s8(input int x);
      return (x >= 128) ? x - 256 : x;
   endfunction

   function automatic int w8(input int x);
      return x & 255;
   endfunction

   function automatic bit sovf(input int x);
      return (x > 127) || (x < -128);
   endfunction

   int mem [256];
   bit model_live = 0;
   int e_ov, e_wen, e_aw, e_wb, e_ovf, e_tk, e_pcn;
   bit e_wb_known;
   int m_op, m_a, m_b, m_pc, m_r;

   always @(posedge clk) begin
      model_live = 1;
      if (!rst_n) begin
         e_ov = 0; e_wen = 0; e_aw = 0; e_wb = 0; e_ovf = 0; e_tk = 0; e_pcn = 0;
         e_wb_known = 1;
      end else if (instr_valid) begin
         m_op = instr[7:4]; m_a = in0; m_b = in1; m_pc = pc; m_r = 0;
         e_ov = 1; e_aw = instr[3:2]; e_wen = 1; e_ovf = 0; e_tk = 0;
         e_pcn = w8(m_pc + 1);
         case (m_op)
            0:  begin m_r = m_a + m_b; e_ovf = sovf(s8(m_a) + s8(m_b)); end
            1:  begin m_r = m_a - m_b; e_ovf = sovf(s8(m_a) - s8(m_b)); end
            2:  m_r = m_a & m_b;
            3:  m_r = m_a | m_b;
            4:  m_r = m_a ^ m_b;
            5:  m_r = 255 - m_b;
`ifdef ALU_SHIFT_EN
            6:  m_r = m_a * (1 << (m_b % 8));
            7:  m_r = m_a / (1 << (m_b % 8));
`else
            6, 7: e_wen = 0;
`endif
            8:  m_r = (s8(m_a) < s8(m_b)) ? 1 : 0;
            9:  m_r = mem[m_b];
            10: begin mem[m_b] = m_a; e_wen = 0; end
            11: begin m_r = m_a + (instr & 3); e_ovf = sovf(s8(m_a) + (instr & 3)); end
            12, 13: begin
               e_wen = 0;
               if ((m_op == 12) == (m_a == m_b)) begin
                  e_tk = 1;
                  e_pcn = w8(m_pc + 1 + s8(jump_offset));
               end
            end
            14: begin e_wen = 0; e_tk = 1; e_pcn = m_b; end
            default: begin e_tk = 1; e_pcn = m_b; e_aw = 3; m_r = m_pc + 1; end
         endcase
         e_wb = w8(m_r);
         e_wb_known = e_wen[0];
      end else begin
         e_ov = 0;
      end
   end

   // Compare every cycle once the model has seen its first edge.
   always @(negedge clk) begin
      if (model_live) begin
         chk("reg_addr_0", reg_addr_0, instr[3:2]);
         chk("reg_addr_1", reg_addr_1, instr[1:0]);
         chk("out_valid", out_valid, e_ov);
         chk("reg_w_en", reg_w_en, e_wen);
         chk("reg_addr_w", reg_addr_w, e_aw);
         if (e_wb_known) chk("wb_data", wb_data, e_wb);
         chk("overflow", overflow, e_ovf);
         chk("branch_taken", branch_taken, e_tk);
         chk("pc_next", pc_next, e_pcn);
      end
   end

   // ---------------- stimulus ----------------
   task automatic exec1(input logic [7:0] ins, input logic [7:0] p, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] jo);
      @(posedge clk); #2;
      rst_n = 1'b1; instr_valid = 1'b1; instr = ins; pc = p; in0 = a; in1 = b; jump_offset = jo;
      @(posedge clk); #2;
      instr_valid = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; instr_valid = 1'b0; instr = '0; pc = '0;
      in0 = '0; in1 = '0; jump_offset = '0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;

      // Fill the data memory so every later load has a known value.
      for (int i = 0; i < 256; i++) begin
         @(posedge clk); #2;
         instr_valid = 1'b1;
         instr = 8'hA0 | 8'($urandom_range(0, 15));
         in0 = 8'($urandom); in1 = 8'(i); pc = 8'($urandom); jump_offset = 8'($urandom);
      end
      @(posedge clk); #2 instr_valid = 1'b0;

      // Reset with a coincident store: outputs clear, memory untouched.
      exec1(8'hA0, 8'h00, 8'h5A, 8'h10, 8'h00);
      @(posedge clk); #2;
      rst_n = 1'b0; instr_valid = 1'b1; instr = 8'hA0; in0 = 8'hFF; in1 = 8'h10;
      @(posedge clk); #2;
      rst_n = 1'b1; instr_valid = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_reg_w_en", reg_w_en, 0);
      chk("rst_wb_data", wb_data, 0);
      chk("rst_pc_next", pc_next, 0);
      chk("rst_reg_addr_w", reg_addr_w, 0);
      exec1(8'h94, 8'h00, 8'h00, 8'h10, 8'h00);
      chk("rst_mem_kept", wb_data, 8'h5A);
      chk("lw_addr_w", reg_addr_w, 1);

      // ADD overflow
      exec1(8'h01, 8'h33, 8'h7F, 8'h01, 8'h00);
      chk("add_wb", wb_data, 8'h80);
      chk("add_ovf", overflow, 1);
      chk("add_wen", reg_w_en, 1);
      chk("add_pcn", pc_next, 8'h34);

      // Store then load
      exec1(8'hA0, 8'h00, 8'hA5, 8'h10, 8'h00);
      chk("sw_wen", reg_w_en, 0);
      exec1(8'h90, 8'h01, 8'h00, 8'h10, 8'h00);
      chk("lw_wb", wb_data, 8'hA5);

      // Branches and jumps
      exec1(8'hC0, 8'h20, 8'h03, 8'h03, 8'hFE);
      chk("beq_taken", branch_taken, 1);
      chk("beq_pcn", pc_next, 8'h1F);
      exec1(8'hD0, 8'h20, 8'h03, 8'h03, 8'hFE);
      chk("bne_taken", branch_taken, 0);
      chk("bne_pcn", pc_next, 8'h21);
      exec1(8'hF0, 8'hFF, 8'h00, 8'h40, 8'h00);
      chk("jal_pcn", pc_next, 8'h40);
      chk("jal_addr_w", reg_addr_w, 3);
      chk("jal_wb", wb_data, 8'h00);
      chk("jal_wen", reg_w_en, 1);

      // Shift
      exec1(8'h60, 8'h00, 8'h81, 8'h01, 8'h00);
`ifdef ALU_SHIFT_EN
      chk("sll_wb", wb_data, 8'h02);
`else
      chk("sll_nop_wen", reg_w_en, 0);
`endif
      chk("sll_ovf", overflow, 0);

      // Random traffic with occasional resets and idle cycles.
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #2;
         rst_n       = ($urandom_range(0, 63) != 0);
         instr_valid = ($urandom_range(0, 9) < 7);
         instr       = 8'($urandom);
         pc          = 8'($urandom);
         in0         = 8'($urandom);
         in1         = ($urandom_range(0, 3) == 0) ? in0 : 8'($urandom);
         jump_offset = 8'($urandom);
      end
      @(posedge clk); #2;
      rst_n = 1'b1; instr_valid = 1'b0;
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
